// File: rtl/serial_word_comparator_if.sv
// serial_word_comparator_if: digit stream in, live and registered compare results out.
interface serial_word_comparator_if #(
  parameter int DIGIT_W = 1
);
  logic start;
  logic valid;
  logic [DIGIT_W-1:0] a;
  logic [DIGIT_W-1:0] b;
  logic gd;
  logic ed;
  logic ld;
  logic gt;
  logic eq;
  logic lt;
  logic busy;
  logic done;
  modport master (
    output start, valid, a, b,
    input  gd, ed, ld, gt, eq, lt, busy, done
  );
  modport slave (
    input  start, valid, a, b,
    output gd, ed, ld, gt, eq, lt, busy, done
  );
endinterface

// File: rtl/serial_word_comparator.sv
// serial_word_comparator: digit-serial magnitude compare of two words, LSB- or MSB-first.
// Define SERIAL_WORD_COMPARATOR_SIGNED_EN for two's-complement operands.
module serial_word_comparator #(
  parameter int DIGIT_W   = 1,
  parameter int WORD_LEN  = 8,
  parameter int MSB_FIRST = 0
) (
  input logic clk,
  input logic reset,
  serial_word_comparator_if.slave bus
);
  localparam int CW = $clog2(WORD_LEN);
  localparam logic [2:0] CMP_G = 3'b100;
  localparam logic [2:0] CMP_E = 3'b010;
  localparam logic [2:0] CMP_L = 3'b001;
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_idx;
  logic [2:0] r_cmp, r_res, w_base, w_upd, w_cmp_nxt;
  logic r_done, w_accept, w_last, w_dgt, w_dlt;
  logic [DIGIT_W-1:0] w_a, w_b;
  // start forces digit 0 and a fresh E state even while a word is running
  assign w_accept = bus.valid && (bus.start || r_state == RUN);
  assign w_idx    = bus.start ? '0 : r_cnt;
  assign w_last   = w_idx == CW'(WORD_LEN - 1);
  assign w_base   = bus.start ? CMP_E : r_cmp;
`ifdef SERIAL_WORD_COMPARATOR_SIGNED_EN
  localparam logic [CW-1:0] MSD = CW'(MSB_FIRST != 0 ? 0 : WORD_LEN - 1);
  localparam logic [DIGIT_W-1:0] SIGN = DIGIT_W'(1) << (DIGIT_W - 1);
  // flipping the sign bit maps two's-complement order onto unsigned order
  assign w_a = bus.a ^ (w_idx == MSD ? SIGN : '0);
  assign w_b = bus.b ^ (w_idx == MSD ? SIGN : '0);
`else
  assign w_a = bus.a;
  assign w_b = bus.b;
`endif
  assign w_dgt = w_a > w_b;
  assign w_dlt = w_a < w_b;
  // MSB-first: first differing digit decides; LSB-first: last differing digit decides
  assign w_upd = (MSB_FIRST != 0 && w_base != CMP_E) ? w_base :
                 w_dgt ? CMP_G : w_dlt ? CMP_L : w_base;
  assign w_cmp_nxt = w_accept ? w_upd : w_base;
  assign {bus.gd, bus.ed, bus.ld} = w_cmp_nxt;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_state_nxt = (w_accept && w_last) ? IDLE : bus.start ? RUN : r_state;
    w_cnt_nxt   = w_accept ? (w_last ? '0 : w_idx + CW'(1)) : w_idx;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cmp   <= CMP_E;
      r_res   <= CMP_E;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cmp   <= w_cmp_nxt;
      r_done  <= w_accept && w_last;
      if (w_accept && w_last) r_res <= w_upd;
    end
  end
  assign {bus.gt, bus.eq, bus.lt} = r_res;
  assign bus.busy = r_state == RUN;
  assign bus.done = r_done;
endmodule
